// File: rtl/aq_axi_pkg.sv
// aq_axi_pkg
//   Shared definitions for the AXI4-Lite single-beat master bridge:
//   controller state encoding (visible on STATUS[7:5]), AXI response
//   codes, fixed PROT/CACHE attributes and the timeout read-data marker.
package aq_axi_pkg;

    // Encoding is software-visible through STATUS, keep it stable.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_WRESP   = 3'd2,
        ST_READ    = 3'd3,
        ST_RDATA   = 3'd4,
        ST_DONE    = 3'd5,
        ST_WAITLOW = 3'd6
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Unprivileged, secure, data access; bufferable + modifiable.
    localparam logic [2:0] AXI_PROT  = 3'b000;
    localparam logic [3:0] AXI_CACHE = 4'b0011;

    // Returned on LOCAL_RDATA when the watchdog fires.
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    // Anything other than OKAY is reported to the local side as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/aq_axi_master_ls.sv
// aq_axi_master_ls
//   Bridges a simple local request bus (CS/RNW/ADDR/BE/WDATA -> ACK/RDATA/ERR)
//   onto a single outstanding AXI4-Lite transaction.
//
//   Parameter : TIMEOUT_CYCLES (16..65535) watchdog limit in ACLK cycles.
//   Macro     : AQ_AXI_MASTER_TIMEOUT_EN enables the watchdog; without it the
//               block waits indefinitely and timeout_flag stays 0.
//
//   Ports
//     ACLK, ARESET          clock, asynchronous active-high reset
//     LOCAL_*               request side; CS is held until ACK, ACK is a
//                           one-cycle pulse carrying RDATA/ERR
//     M_AXI_AW*/W*/B*       AXI4-Lite write channels
//     M_AXI_AR*/R*          AXI4-Lite read channels
//     STATUS                {state[2:0], timeout_flag, 4'd0}
module aq_axi_master_ls
    import aq_axi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        ACLK,
    input  logic        ARESET,

    input  logic        LOCAL_CS,
    input  logic        LOCAL_RNW,
    input  logic [31:0] LOCAL_ADDR,
    input  logic [3:0]  LOCAL_BE,
    input  logic [31:0] LOCAL_WDATA,
    output logic        LOCAL_ACK,
    output logic [31:0] LOCAL_RDATA,
    output logic        LOCAL_ERR,

    output logic [31:0] M_AXI_AWADDR,
    output logic [2:0]  M_AXI_AWPROT,
    output logic [3:0]  M_AXI_AWCACHE,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,

    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,

    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,

    output logic [31:0] M_AXI_ARADDR,
    output logic [2:0]  M_AXI_ARPROT,
    output logic [3:0]  M_AXI_ARCACHE,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,

    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY,

    output logic [7:0]  STATUS
);

    if (TIMEOUT_CYCLES < 16 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("aq_axi_master_ls: TIMEOUT_CYCLES out of range 16..65535");
    end

    state_t      state;
    logic [31:0] addr_r;
    logic [3:0]  be_r;
    logic [31:0] wdata_r;
    logic        rnw_r;
    logic        issued;     // VALIDs have been raised for this request
    logic        awvalid_r, wvalid_r, arvalid_r;
    logic        bready_r, rready_r;
    logic        ack_r, err_r;
    logic [31:0] rdata_r;
    logic        timeout_flag;

    // A write channel is still pending while its VALID is up and not yet taken.
    logic aw_left, w_left;
    assign aw_left = awvalid_r & ~M_AXI_AWREADY;
    assign w_left  = wvalid_r  & ~M_AXI_WREADY;

`ifdef AQ_AXI_MASTER_TIMEOUT_EN
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] tmo_cnt;
    logic        tmo_flag_r;
    logic        busy;
    assign busy = (state == ST_WRITE) || (state == ST_WRESP) ||
                  (state == ST_READ)  || (state == ST_RDATA);
    assign timeout_flag = tmo_flag_r;
`else
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= ST_IDLE;
            addr_r    <= '0;
            be_r      <= '0;
            wdata_r   <= '0;
            rnw_r     <= 1'b0;
            issued    <= 1'b0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            arvalid_r <= 1'b0;
            bready_r  <= 1'b0;
            rready_r  <= 1'b0;
            ack_r     <= 1'b0;
            err_r     <= 1'b0;
            rdata_r   <= '0;
`ifdef AQ_AXI_MASTER_TIMEOUT_EN
            tmo_cnt    <= '0;
            tmo_flag_r <= 1'b0;
`endif
        end else begin
            ack_r <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (LOCAL_CS) begin
                        addr_r  <= LOCAL_ADDR;
                        be_r    <= LOCAL_BE;
                        wdata_r <= LOCAL_WDATA;
                        rnw_r   <= LOCAL_RNW;
                        issued  <= 1'b0;
                        state   <= LOCAL_RNW ? ST_READ : ST_WRITE;
                    end
                end

                // First cycle in WRITE/READ raises the VALIDs from the
                // captured request; handshakes are tracked afterwards.
                ST_WRITE, ST_READ: begin
                    if (!issued) begin
                        issued <= 1'b1;
                        if (rnw_r) begin
                            arvalid_r <= 1'b1;
                        end else begin
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                        end
                    end else if (rnw_r) begin
                        if (M_AXI_ARREADY) begin
                            arvalid_r <= 1'b0;
                            rready_r  <= 1'b1;
                            state     <= ST_RDATA;
                        end
                    end else begin
                        // AW and W retire independently, in either order.
                        if (awvalid_r && M_AXI_AWREADY) awvalid_r <= 1'b0;
                        if (wvalid_r  && M_AXI_WREADY)  wvalid_r  <= 1'b0;
                        if (!aw_left && !w_left) begin
                            bready_r <= 1'b1;
                            state    <= ST_WRESP;
                        end
                    end
                end

                ST_WRESP: begin
                    if (M_AXI_BVALID) begin
                        bready_r <= 1'b0;
                        err_r    <= resp_is_err(M_AXI_BRESP);
                        rdata_r  <= '0;
                        ack_r    <= 1'b1;
                        state    <= ST_DONE;
                    end
                end

                ST_RDATA: begin
                    if (M_AXI_RVALID) begin
                        rready_r <= 1'b0;
                        err_r    <= resp_is_err(M_AXI_RRESP);
                        rdata_r  <= M_AXI_RDATA;
                        ack_r    <= 1'b1;
                        state    <= ST_DONE;
                    end
                end

                // ACK was registered on entry, so it is high for DONE only.
                ST_DONE: state <= ST_WAITLOW;

                // Wait for the requester to release CS so a held CS cannot
                // launch a second access.
                ST_WAITLOW: if (!LOCAL_CS) state <= ST_IDLE;

                default: state <= ST_IDLE;
            endcase

`ifdef AQ_AXI_MASTER_TIMEOUT_EN
            // Placed after the case so an expiry overrides any handshake
            // update made in the same cycle.
            if (state == ST_IDLE) begin
                tmo_cnt <= '0;
            end else if (busy) begin
                if (tmo_cnt == TMO_LIMIT) begin
                    awvalid_r  <= 1'b0;
                    wvalid_r   <= 1'b0;
                    arvalid_r  <= 1'b0;
                    bready_r   <= 1'b0;
                    rready_r   <= 1'b0;
                    err_r      <= 1'b1;
                    rdata_r    <= TIMEOUT_RDATA;
                    ack_r      <= 1'b1;
                    tmo_flag_r <= 1'b1;
                    state      <= ST_DONE;
                end else begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                end
            end
`endif
        end
    end

    assign LOCAL_ACK   = ack_r;
    assign LOCAL_RDATA = rdata_r;
    assign LOCAL_ERR   = err_r;

    assign M_AXI_AWADDR  = addr_r;
    assign M_AXI_AWPROT  = AXI_PROT;
    assign M_AXI_AWCACHE = AXI_CACHE;
    assign M_AXI_AWVALID = awvalid_r;

    assign M_AXI_WDATA  = wdata_r;
    assign M_AXI_WSTRB  = be_r;
    assign M_AXI_WVALID = wvalid_r;

    assign M_AXI_BREADY = bready_r;

    assign M_AXI_ARADDR  = addr_r;
    assign M_AXI_ARPROT  = AXI_PROT;
    assign M_AXI_ARCACHE = AXI_CACHE;
    assign M_AXI_ARVALID = arvalid_r;

    assign M_AXI_RREADY = rready_r;

    assign STATUS = {state, timeout_flag, 4'd0};

endmodule

// File: tb/tb_aq_axi_master_ls.sv
// tb_aq_axi_master_ls
//   Drives local requests against a randomized-latency AXI4-Lite slave model
//   and checks the bridge against a transaction-level reference: expected
//   AXI payloads, ACK count, ACK latency, RDATA/ERR and VALID stability.
//   With AQ_AXI_MASTER_TIMEOUT_EN defined the watchdog path is also exercised.
module tb_aq_axi_master_ls;

`ifdef AQ_AXI_MASTER_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic        ACLK, ARESET;
    logic        LOCAL_CS, LOCAL_RNW;
    logic [31:0] LOCAL_ADDR, LOCAL_WDATA;
    logic [3:0]  LOCAL_BE;
    logic        LOCAL_ACK, LOCAL_ERR;
    logic [31:0] LOCAL_RDATA;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [2:0]  AWPROT, ARPROT;
    logic [3:0]  AWCACHE, ARCACHE, WSTRB;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;
    logic [7:0]  STATUS;

    aq_axi_master_ls #(.TIMEOUT_CYCLES(TMO)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .LOCAL_CS(LOCAL_CS), .LOCAL_RNW(LOCAL_RNW), .LOCAL_ADDR(LOCAL_ADDR),
        .LOCAL_BE(LOCAL_BE), .LOCAL_WDATA(LOCAL_WDATA),
        .LOCAL_ACK(LOCAL_ACK), .LOCAL_RDATA(LOCAL_RDATA), .LOCAL_ERR(LOCAL_ERR),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWCACHE(AWCACHE),
        .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID),
        .M_AXI_WREADY(WREADY),
        .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
        .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARCACHE(ARCACHE),
        .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID),
        .M_AXI_RREADY(RREADY),
        .STATUS(STATUS)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Slave configuration for the current transaction.
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [1:0]  cfg_bresp, cfg_rresp;
    logic [31:0] cfg_rdata;
    bit          tmo_mode   = 0;
    bit          tmo_sticky = 0;

    // Observations.
    int cyc = 0;
    int aw_hs, w_hs, b_hs, ar_hs, r_hs, b_sent, r_sent;
    int aw_edge, w_edge, ar_hi;
    int ack_cnt = 0, last_ack_edge;
    logic [31:0] ack_rdata;
    logic        ack_err;
    logic [31:0] aw_q[$], w_q[$], ar_q[$];
    logic [3:0]  s_q[$];

    // Monitor: samples at the active edge (pre-update values).
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;
    initial begin
        p_awv = 0; p_wv = 0; p_arv = 0;
        forever begin
            @(posedge ACLK);
            cyc++;
            if (ARESET) begin
                p_awv = 0; p_wv = 0; p_arv = 0;
            end else begin
                if (p_awv && !p_awr) begin
                    chk("aw_held", 32'(AWVALID), 1);
                    chk("aw_addr_stable", AWADDR, p_awaddr);
                end
                if (p_wv && !p_wr) begin
                    chk("w_held", 32'(WVALID), 1);
                    chk("w_data_stable", WDATA, p_wdata);
                    chk("w_strb_stable", 32'(WSTRB), 32'(p_wstrb));
                end
                if (p_arv && !p_arr && !tmo_mode) begin
                    chk("ar_held", 32'(ARVALID), 1);
                    chk("ar_addr_stable", ARADDR, p_araddr);
                end
                if (AWVALID && AWREADY) begin
                    aw_hs++; aw_edge = cyc; aw_q.push_back(AWADDR);
                    chk("aw_attr", 32'({AWCACHE, AWPROT}), 32'h18);
                end
                if (WVALID && WREADY) begin
                    w_hs++; w_edge = cyc; w_q.push_back(WDATA); s_q.push_back(WSTRB);
                end
                if (ARVALID && ARREADY) begin
                    ar_hs++; ar_q.push_back(ARADDR);
                    chk("ar_attr", 32'({ARCACHE, ARPROT}), 32'h18);
                end
                if (BVALID && BREADY) b_hs++;
                if (RVALID && RREADY) r_hs++;
                if (ARVALID) ar_hi++;
                if (LOCAL_ACK) begin
                    ack_cnt++; last_ack_edge = cyc;
                    ack_rdata = LOCAL_RDATA; ack_err = LOCAL_ERR;
                end
                p_awv = AWVALID; p_awr = AWREADY; p_awaddr = AWADDR;
                p_wv = WVALID; p_wr = WREADY; p_wdata = WDATA; p_wstrb = WSTRB;
                p_arv = ARVALID; p_arr = ARREADY; p_araddr = ARADDR;
            end
        end
    end

    // Slave model: updates its outputs on the falling edge.
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    initial begin
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        ARREADY = 0; RVALID = 0; RRESP = 0; RDATA = 0;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; b_sent = 0; r_sent = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
                aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; b_sent = 0; r_sent = 0;
                aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
            end else begin
                if (AWVALID) begin AWREADY = (aw_wait >= aw_dly); aw_wait++; end
                else begin AWREADY = 0; aw_wait = 0; end
                if (WVALID) begin WREADY = (w_wait >= w_dly); w_wait++; end
                else begin WREADY = 0; w_wait = 0; end
                if (ARVALID) begin ARREADY = (ar_wait >= ar_dly); ar_wait++; end
                else begin ARREADY = 0; ar_wait = 0; end

                if (BVALID && b_hs == b_sent) BVALID = 0;
                if (!BVALID && aw_hs > b_sent && w_hs > b_sent) begin
                    if (b_wait >= b_dly) begin
                        BVALID = 1; BRESP = cfg_bresp; b_sent++; b_wait = 0;
                    end else b_wait++;
                end
                if (RVALID && r_hs == r_sent) RVALID = 0;
                if (!RVALID && ar_hs > r_sent) begin
                    if (r_wait >= r_dly) begin
                        RVALID = 1; RRESP = cfg_rresp; RDATA = cfg_rdata; r_sent++; r_wait = 0;
                    end else r_wait++;
                end
            end
        end
    end

    task automatic set_cfg(input int awd, input int wd, input int bd, input int ard,
                           input int rd, input logic [1:0] br, input logic [1:0] rr,
                           input logic [31:0] rdat);
        aw_dly = awd; w_dly = wd; b_dly = bd; ar_dly = ard; r_dly = rd;
        cfg_bresp = br; cfg_rresp = rr; cfg_rdata = rdat;
    endtask

    // One local request; expectations come from the slave configuration.
    task automatic run_txn(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, input int hold_after, input int drop_at,
                           input bit exp_tmo);
        int ack0, aw0, w0, ar0, start, waited, exp_lat;
        logic [31:0] exp_rd;
        logic        exp_err;
        aw_q.delete(); w_q.delete(); s_q.delete(); ar_q.delete();
        ack0 = ack_cnt; aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs;
        if (exp_tmo) begin
            exp_lat = TMO + 2; exp_rd = 32'hDEAD_BEEF; exp_err = 1;
        end else if (rnw) begin
            exp_lat = 4 + ar_dly + r_dly; exp_rd = cfg_rdata; exp_err = (cfg_rresp != 2'b00);
        end else begin
            exp_lat = 4 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
            exp_rd = 0; exp_err = (cfg_bresp != 2'b00);
        end
        @(negedge ACLK);
        LOCAL_CS = 1; LOCAL_RNW = rnw; LOCAL_ADDR = addr; LOCAL_BE = be; LOCAL_WDATA = wd;
        start = cyc + 1;
        waited = 0;
        while (ack_cnt == ack0 && waited < 400) begin
            @(negedge ACLK);
            waited++;
            if (drop_at > 0 && waited == drop_at) LOCAL_CS = 0;
        end
        chk("ack_seen", 32'(ack_cnt != ack0), 1);
        repeat (hold_after) @(negedge ACLK);
        LOCAL_CS = 0; LOCAL_ADDR = $urandom; LOCAL_WDATA = $urandom;
        repeat (3) @(negedge ACLK);
        chk("ack_pulses", ack_cnt - ack0, 1);
        chk("latency", last_ack_edge - start, exp_lat);
        chk("rdata", ack_rdata, exp_rd);
        chk("err", 32'(ack_err), 32'(exp_err));
        if (exp_tmo) tmo_sticky = 1;
        chk("tmo_flag", 32'(STATUS[4]), 32'(tmo_sticky));
        chk("state_idle", 32'(STATUS[7:5]), 0);
        if (rnw) begin
            chk("ar_count", ar_hs - ar0, exp_tmo ? 0 : 1);
            chk("aw_count_rd", (aw_hs - aw0) + (w_hs - w0), 0);
            if (!exp_tmo) begin
                chk("ar_q_size", ar_q.size(), 1);
                if (ar_q.size() != 0) chk("araddr", ar_q.pop_front(), addr);
            end
        end else begin
            chk("aw_count", aw_hs - aw0, 1);
            chk("w_count", w_hs - w0, 1);
            chk("ar_count_wr", ar_hs - ar0, 0);
            chk("aw_q_size", aw_q.size() + w_q.size(), 2);
            if (aw_q.size() != 0) chk("awaddr", aw_q.pop_front(), addr);
            if (w_q.size() != 0)  chk("wdata", w_q.pop_front(), wd);
            if (s_q.size() != 0)  chk("wstrb", 32'(s_q.pop_front()), 32'(be));
        end
    endtask

    initial begin
        int ack0, waited, hi0;
        ARESET = 1; LOCAL_CS = 0; LOCAL_RNW = 0; LOCAL_ADDR = 0; LOCAL_BE = 0; LOCAL_WDATA = 0;
        set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        repeat (3) @(negedge ACLK);
        chk("rst_status", 32'(STATUS), 0);
        chk("rst_valids", 32'({AWVALID, WVALID, ARVALID, BREADY, RREADY}), 0);
        chk("rst_ack_err", 32'({LOCAL_ACK, LOCAL_ERR}), 0);
        chk("rst_rdata", LOCAL_RDATA, 0);
        chk("rst_addr", AWADDR | ARADDR | WDATA, 0);
        @(negedge ACLK); ARESET = 0;

        // Zero-wait write.
        set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        run_txn(0, 32'h0000_0010, 4'hF, 32'h1234_5678, 0, 0, 0);

        // Read with AR accepted on the fourth VALID cycle.
        set_cfg(0, 0, 0, 3, 0, 2'b00, 2'b00, 32'hCAFE_F00D);
        hi0 = ar_hi;
        run_txn(1, 32'h0000_0020, 4'h0, 32'h0, 0, 0, 0);
        chk("ar_valid_cycles", ar_hi - hi0, 4);

        // W accepted 5 cycles ahead of AW, slave error.
        set_cfg(5, 0, 0, 0, 0, 2'b10, 2'b00, 32'h0);
        run_txn(0, 32'h0000_0104, 4'h3, 32'hA5A5_0F0F, 0, 0, 0);
        chk("w_before_aw", aw_edge - w_edge, 5);

        // CS held 10 cycles after ACK: still a single access.
        set_cfg(0, 0, 0, 0, 1, 2'b00, 2'b11, 32'h1357_9BDF);
        run_txn(1, 32'h0000_0200, 4'h0, 32'h0, 10, 0, 0);
        set_cfg(1, 2, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        run_txn(0, 32'h0000_0300, 4'h8, 32'h0BAD_CAFE, 10, 0, 0);

        // CS dropped mid-flight must not abort.
        set_cfg(2, 2, 3, 0, 0, 2'b01, 2'b00, 32'h0);
        run_txn(0, 32'h0000_0400, 4'h5, 32'h7777_8888, 0, 2, 0);
        set_cfg(0, 0, 0, 2, 3, 2'b00, 2'b00, 32'h2468_ACE0);
        run_txn(1, 32'h0000_0500, 4'h0, 32'h0, 0, 2, 0);

        // Randomized traffic.
        for (int i = 0; i < 16; i++) begin
            set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom);
            run_txn(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 4'($urandom),
                    $urandom, $urandom_range(0, 2),
                    ($urandom_range(0, 3) == 0) ? 2 : 0, 0);
        end

        // Reset while waiting for B.
        set_cfg(0, 0, 10, 0, 0, 2'b00, 2'b00, 32'h0);
        ack0 = ack_cnt;
        @(negedge ACLK);
        LOCAL_CS = 1; LOCAL_RNW = 0; LOCAL_ADDR = 32'h0000_0600; LOCAL_BE = 4'hF;
        LOCAL_WDATA = 32'hFEED_0001;
        waited = 0;
        while (STATUS[7:5] != 3'd2 && waited < 50) begin
            @(negedge ACLK);
            waited++;
        end
        chk("reach_wresp", 32'(STATUS[7:5]), 2);
        @(negedge ACLK);
        chk("bready_pre_rst", 32'(BREADY), 1);
        #2 ARESET = 1;
        #1;
        chk("rst_bready", 32'(BREADY), 0);
        chk("rst_state", 32'(STATUS), 0);
        chk("rst_mid_valids", 32'({AWVALID, WVALID, ARVALID, RREADY, LOCAL_ACK}), 0);
        LOCAL_CS = 0;
        repeat (2) @(negedge ACLK);
        ARESET = 0;
        repeat (5) @(negedge ACLK);
        chk("no_ack_aborted", ack_cnt - ack0, 0);
        tmo_sticky = 0;
        set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        run_txn(0, 32'h0000_0600, 4'hF, 32'hFEED_0002, 0, 0, 0);

`ifdef AQ_AXI_MASTER_TIMEOUT_EN
        // AR never accepted: watchdog completes the request.
        tmo_mode = 1;
        set_cfg(0, 0, 0, 100000, 0, 2'b00, 2'b00, 32'h0);
        run_txn(1, 32'h0000_0700, 4'h0, 32'h0, 0, 0, 1);
        tmo_mode = 0;
        set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        run_txn(0, 32'h0000_0800, 4'hF, 32'h0000_0042, 0, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aq_axi_master_ls.md
AQ_AXI_MASTER_LS -- requirements
Module: aq_axi_master_ls

Interface
REQ-001 The block SHALL take one parameter: TIMEOUT_CYCLES, default 1024, the watchdog limit in ACLK cycles (legal range 16..65535).
REQ-002 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-003 Ports SHALL be as follows:
- ACLK  in  1  clock
- ARESET  in  1  async active-high reset
- LOCAL_CS  in  1  request, held until LOCAL_ACK
- LOCAL_RNW  in  1  1=read, 0=write
- LOCAL_ADDR  in  32  byte address
- LOCAL_BE  in  4  write byte enables
- LOCAL_WDATA  in  32  write data
- LOCAL_ACK  out  1  one-cycle completion pulse
- LOCAL_RDATA  out  32  read data, valid while LOCAL_ACK=1
- LOCAL_ERR  out  1  error flag, valid while LOCAL_ACK=1
- M_AXI_AWADDR/AWPROT/AWCACHE/AWVALID/AWREADY  out/out/out/out/in  32/3/4/1/1  write address
- M_AXI_WDATA/WSTRB/WVALID/WREADY  out/out/out/in  32/4/1/1  write data
- M_AXI_BRESP/BVALID/BREADY  in/in/out  2/1/1  write response
- M_AXI_ARADDR/ARPROT/ARCACHE/ARVALID/ARREADY  out/out/out/out/in  32/3/4/1/1  read address
- M_AXI_RDATA/RRESP/RVALID/RREADY  in/in/in/out  32/2/1/1  read data
- STATUS  out  8  {state[2:0], timeout_flag, 4'd0}

Function
REQ-004 The block SHALL implement states IDLE, WRITE, WRESP, READ, RDATA, DONE, WAITLOW.
REQ-005 In IDLE, when LOCAL_CS=1, the block SHALL register ADDR, BE, WDATA and RNW, then enter READ if RNW=1 or WRITE if RNW=0.
REQ-006 On entry to WRITE, AWVALID and WVALID SHALL both assert in the next cycle with the registered values.
REQ-007 Each of AWVALID and WVALID SHALL drop independently on its own handshake (AW and W in any order or the same cycle).
REQ-008 The block SHALL enter WRESP once both the AW and W handshakes have completed.
REQ-009 In WRESP, BREADY SHALL be 1; on BVALID the block SHALL capture err = (BRESP != 2'b00) and enter DONE.
REQ-010 In READ, ARVALID SHALL be 1 until ARREADY, then the block SHALL enter RDATA.
REQ-011 In RDATA, RREADY SHALL be 1; on RVALID the block SHALL capture RDATA, set err = (RRESP != 2'b00) and enter DONE.
REQ-012 In DONE, LOCAL_ACK SHALL be 1 for exactly one cycle, with LOCAL_RDATA (0 for writes) and LOCAL_ERR driven; the block SHALL then enter WAITLOW.
REQ-013 In WAITLOW, the block SHALL return to IDLE only when LOCAL_CS=0; a held CS SHALL never start a second transaction.
REQ-014 AWPROT/ARPROT SHALL be 3'b000 and AWCACHE/ARCACHE SHALL be 4'b0011.
REQ-015 Every VALID, once asserted, SHALL stay high, with stable payload, until its READY handshake.
REQ-016 Minimum latency from CS rise to ACK, with zero-wait slave ready signals, SHALL be: write 4 cycles, read 4 cycles.
REQ-017 LOCAL_CS deasserting mid-transaction SHALL NOT abort the AXI transaction; the transaction SHALL complete and ACK SHALL still pulse.

Reset
REQ-018 While ARESET=1, the block SHALL be in state IDLE.
REQ-019 While ARESET=1, all VALID/READY outputs, LOCAL_ACK and LOCAL_ERR SHALL be 0.
REQ-020 While ARESET=1, all address/data registers, LOCAL_RDATA, STATUS and timeout_flag SHALL be 0.
REQ-021 Reset asserted mid-transaction SHALL drop all VALIDs asynchronously; no ACK SHALL be issued for the aborted request.

Configuration
REQ-022 With macro AQ_AXI_MASTER_TIMEOUT_EN defined, a 16-bit counter SHALL clear on leaving IDLE and count every cycle in WRITE, WRESP, READ and RDATA.
REQ-023 With AQ_AXI_MASTER_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL drop all VALIDs, set timeout_flag, and enter DONE with LOCAL_ERR=1 and LOCAL_RDATA=32'hDEAD_BEEF.
REQ-024 With AQ_AXI_MASTER_TIMEOUT_EN defined, timeout_flag SHALL be sticky until reset.
REQ-025 Without AQ_AXI_MASTER_TIMEOUT_EN, the block SHALL contain no counter, SHALL wait indefinitely, and SHALL hold timeout_flag at 0.

Structure
REQ-026 Package aq_axi_pkg SHALL hold the state encoding, the RESP codes (OKAY, EXOKAY, SLVERR, DECERR), and the PROT/CACHE constants.
REQ-027 The block SHALL be a single module with no sub-module.

Verification
REQ-028 Write 0x0000_0010 <- 0x1234_5678, BE=4'hF, ready signals always 1, BRESP=OKAY -> AW/W payloads match; ACK 4 cycles after CS; ERR=0.
REQ-029 Read 0x20, ARREADY delayed 3 cycles, RDATA=0xCAFE_F00D, RRESP=OKAY -> ARVALID held stable for 4 cycles; LOCAL_RDATA=0xCAFE_F00D with ACK.
REQ-030 Write with WREADY 5 cycles before AWREADY, then BRESP=SLVERR -> WVALID drops first, AWVALID drops later; single ACK with ERR=1.
REQ-031 CS held high for 10 cycles after ACK -> exactly one AXI transaction, one ACK pulse.
REQ-032 With AQ_AXI_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, read with ARREADY never asserted -> ACK at cycle 16+2, ERR=1, RDATA=0xDEAD_BEEF, STATUS[4]=1.
REQ-033 ARESET pulsed while in WRESP -> BREADY=0 and state IDLE immediately; the next write completes normally.
